// File: rtl/siso_pkg.sv
// Shared defaults for the serial-in serial-out shift register.
package siso_pkg;

    localparam int unsigned SISO_DEFAULT_WIDTH       = 4;
    localparam logic        SISO_DEFAULT_RESET_VALUE = 1'b0;

endpackage : siso_pkg

// File: rtl/siso.sv
// Serial-in serial-out shift register: one bit enters per enabled edge and
// leaves WIDTH enabled edges later; the whole register is exported for observation.
module siso
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH       = SISO_DEFAULT_WIDTH,
    parameter logic        RESET_VALUE = SISO_DEFAULT_RESET_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] srtb
);

    logic [WIDTH-1:0] sr;

    // Bit 0 holds the newest sample; reset wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {WIDTH{RESET_VALUE}};
        end else if (en) begin
            sr <= {sr[WIDTH-2:0], sin};
        end
    end

    assign srtb = sr;
    assign sout = sr[WIDTH-1];

endmodule : siso

// File: tb/tb_siso.sv
// Randomised and directed bench for siso; a bit-history model feeds a
// scoreboard queue that an independent monitor drains.
module tb_siso;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sin = 1'b0;
    logic         sout;
    logic [W-1:0] srtb;

    int vectors     = 0;
    int miscompares = 0;

    // Model: captured bits, newest first; missing positions read as reset value.
    logic         hist[$];
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    event         sample_ev;
    bit           stim_done = 1'b0;

    siso #(.WIDTH(W), .RESET_VALUE(1'b0)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sin  (sin),
        .sout (sout),
        .srtb (srtb)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_srtb();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W); i++) begin
            v[i] = (i < hist.size()) ? hist[i] : 1'b0;
        end
        return v;
    endfunction

    task automatic expect_now(input string nm);
        exp_q.push_back(model_srtb());
        name_q.push_back(nm);
        ->sample_ev;
    endtask

    // One clock edge with the given inputs, then post the expected register.
    task automatic step(input logic r, input logic e, input logic s, input string nm);
        @(negedge clk);
        rst = r;
        en  = e;
        sin = s;
        @(posedge clk);
        if (r) begin
            hist.delete();
        end else if (e) begin
            hist.push_front(s);
            if (hist.size() > int'(W)) void'(hist.pop_back());
        end
        expect_now(nm);
    endtask

    // Assert reset between edges and check the clear before the next edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        rst = 1'b1;
        hist.delete();
        expect_now(nm);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n, input string nm);
        logic [31:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, b[i], nm);
        end
    endtask

    // Monitor: samples shortly after each expected update and compares.
    initial begin : monitor
        logic [W-1:0] exp_v;
        string        nm;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_underflow: sample with no expected entry");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                vectors++;
                if (srtb !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s srtb: got %b expected %b at %0t", nm, srtb, exp_v, $time);
                end
                vectors++;
                if (sout !== exp_v[W-1]) begin
                    miscompares++;
                    $display("FAIL %s sout: got %b expected %b at %0t", nm, sout, exp_v[W-1], $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus did not complete by %0t", $time);
            $fatal(1, "timeout");
        end
    end

    initial begin : stimulus
        // Reset held across edges.
        step(1'b1, 1'b1, 1'b1, "reset_hold");
        step(1'b1, 1'b0, 1'b0, "reset_hold");

        // Basic shift 1,0,1,1 then flush with zeros.
        shift_bits(32'b1011, 4, "basic_shift");
        shift_bits(32'b0000, 4, "flush");

        // Hold with sin toggling, then re-enable.
        shift_bits(32'b1011, 4, "reload");
        step(1'b0, 1'b0, 1'b0, "hold");
        step(1'b0, 1'b0, 1'b1, "hold");
        step(1'b0, 1'b0, 1'b0, "hold");
        step(1'b0, 1'b1, 1'b0, "reenable");

        // Reach 1101, then reset across an enabled edge, then resume.
        step(1'b0, 1'b1, 1'b1, "to_1101");
        step(1'b1, 1'b1, 1'b1, "reset_priority");
        step(1'b0, 1'b1, 1'b1, "after_reset");

        // Asynchronous clear between edges with a preloaded register.
        shift_bits(32'b1111, 4, "preload");
        async_reset("async_reset");
        step(1'b1, 1'b1, 1'b1, "async_reset_edge");

        // Long stream: sout is sin delayed by four enabled edges.
        shift_bits(32'b010110110111, 12, "long_stream");

        // Randomised enable, data and occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom), "random");
        end

        repeat (3) @(posedge clk);
        stim_done = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_siso
